mux_op_sequencer: RTL and testbench
===================================

// Module: mux_op_sequencer
// PURPOSE
//  Upstream controller for the 16-bit 4:1 operand mux (a,b,c,d,op -> out).
//  - Accepts one bundle of four WIDTH-bit words; holds them on mux_a..mux_d.
//  - Steps mux_op through the words enabled by a 4-bit mask.
//  - Captures each mux_out and emits the selected words in order on a valid/ready stream.
// PARAMETERS
//  WIDTH  16  word width of bundle, mux operands and output stream
// PORTS
//  clk        in   1      single clock; all state updates on posedge
//  rst_n      in   1      synchronous reset, active-low
//  in_valid   in   1      bundle valid
//  in_ready   out  1      bundle accepted when in_valid && in_ready
//  in_a..in_d in   WIDTH  bundle words, index 0..3
//  in_mask    in   4      bit i=1 -> emit word i; 4'b0000 treated as 4'b1111
//  mux_a..d   out  WIDTH  registered operands to mux a,b,c,d
//  mux_op     out  2      registered select to mux op
//  mux_out    in   WIDTH  mux result
//  out_valid  out  1      out_data valid
//  out_ready  in   1      consumer ready
//  out_data   out  WIDTH  captured word
//  out_idx    out  2      index (0..3) of word in out_data
//  out_last   out  1      final enabled word of the bundle
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  - Clock and reset:
//    - Single clock.
//    - Synchronous active-low reset: while rst_n==0 at posedge, all registers clear.
//    - Reset values: state=IDLE; mux_a..d, mux_op, out_data, out_idx = 0;
//      out_valid, out_last, busy = 0.
//    - in_ready is forced to 0 while rst_n==0.
//    - Reset mid-bundle abandons the bundle. No partial output remains.
//  - Mux constraint: the mux output updates only when op changes. Therefore every
//    bundle passes through PRIME so that op always makes a transition.
//  - State machine:
//    - IDLE:
//      - in_ready=1.
//      - On accept, latch in_a..d into mux_a..d and latch the effective mask into msk.
//      - Set idx = lowest set bit of msk, then go to PRIME.
//    - PRIME (1 cycle): mux_op <= idx ^ 2'b01, then go to SEL.
//    - SEL (1 cycle):
//      - mux_op <= idx.
//    - CAP (1 cycle):
//      - out_data <= mux_out; out_idx <= idx; out_valid <= 1.
//      - out_last <= (no set bit in msk above idx). Then go to EMIT.
//    - EMIT:
//      - Hold out_data, out_idx and out_last stable while out_valid && !out_ready.
//      - On handshake, out_valid <= 0.
//      - If out_last, go to IDLE.
//      - Otherwise idx <= next set bit above idx, then go to PRIME.
//  - Word order is ascending index; masked-off words are skipped entirely.
//  - Latency:
//    - Bundle accepted at cycle T -> out_valid=1 at T+4.
//    - Handshake at cycle k -> next word valid at k+4.
//    - Last handshake at k -> in_ready=1 at k+1.
//  - Throughput: one bundle in flight; in_ready=0 in every non-IDLE state.
//  - Bundle inputs and in_mask are sampled only at accept; changes while busy are ignored.
//  - out_ready is ignored while out_valid=0.
//  - No arithmetic on data: words pass bit-exact, WIDTH bits, no extension.
// TESTING
//  1. Reset, then bundle a=7, b=FFFD, c=0038, d=F16D, mask=F, out_ready=1:
//     - out_data = 0007, FFFD, 0038, F16D; out_idx = 0..3.
//     - out_last only on F16D; first out_valid 4 cycles after accept.
//  2. Mask=4'b1000 after a bundle ending on idx 3, with d changed to 1234:
//     - Single word 1234, out_last=1.
//     - Confirms PRIME forces an op transition (no stale F16D).
//  3. Mask=4'b0000, bundle 8,4,45,F0FD -> all four words emitted (mask treated as F).
//  4. Backpressure: out_ready=0 for 5 cycles on word 1 of mask=4'b0101:
//     - out_data=c stays stable and valid until ready; no word is dropped or duplicated.
//  5. While busy, toggle in_valid with new data:
//     - in_ready stays 0; emitted words still come from the original bundle.
//  6. rst_n=0 during EMIT:
//     - Next cycle out_valid=0, busy=0, mux_op=0; in_ready=1 after release.
//     - A new bundle then completes normally.

Source files
------------

// File: rtl/mux_op_sequencer.sv
// Sequencer feeding a 4:1 operand mux: latches a bundle, walks the enabled words
// through mux_op (forcing an op transition each time) and streams the results.
module mux_op_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic [WIDTH-1:0] in_d,
  input  logic [3:0]       in_mask,
  output logic [WIDTH-1:0] mux_a,
  output logic [WIDTH-1:0] mux_b,
  output logic [WIDTH-1:0] mux_c,
  output logic [WIDTH-1:0] mux_d,
  output logic [1:0]       mux_op,
  input  logic [WIDTH-1:0] mux_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_idx,
  output logic             out_last,
  output logic             busy,
  output logic [2:0]       state_dbg
);

  // Streams: a transfer happens on a rising edge where valid && ready are both 1;
  // the producer holds data stable while valid && !ready.

  typedef enum logic [2:0] {IDLE, PRIME, SEL, CAP, EMIT} state_t;

  state_t     state, state_nxt;
  logic [3:0] msk;
  logic [1:0] idx;
  logic [3:0] eff_mask;
  logic [3:0] higher;
  logic [1:0] next_idx;
  logic       last_word;
  logic       handshake;

  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    lowest_set = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) lowest_set = 2'(i);
    end
  endfunction

  assign eff_mask  = (in_mask == 4'b0000) ? 4'b1111 : in_mask;
  assign higher    = msk & (4'b1110 << idx);
  assign last_word = (higher == 4'b0000);
  assign next_idx  = lowest_set(higher);
  assign handshake = out_valid && out_ready;

  assign in_ready  = rst_n && (state == IDLE);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = PRIME;
      PRIME:   state_nxt = SEL;
      SEL:     state_nxt = CAP;
      CAP:     state_nxt = EMIT;
      EMIT:    if (handshake) state_nxt = out_last ? IDLE : PRIME;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      msk       <= '0;
      idx       <= '0;
      mux_a     <= '0;
      mux_b     <= '0;
      mux_c     <= '0;
      mux_d     <= '0;
      mux_op    <= '0;
      out_data  <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            mux_a <= in_a;
            mux_b <= in_b;
            mux_c <= in_c;
            mux_d <= in_d;
            msk   <= eff_mask;
            idx   <= lowest_set(eff_mask);
          end
        end
        // The mux only refreshes on an op change, so step away from idx first.
        PRIME: mux_op <= idx ^ 2'b01;
        SEL:   mux_op <= idx;
        CAP: begin
          out_data  <= mux_out;
          out_idx   <= idx;
          out_valid <= 1'b1;
          out_last  <= last_word;
        end
        EMIT: begin
          if (handshake) begin
            out_valid <= 1'b0;
            if (!out_last) idx <= next_idx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_op_sequencer.sv
// Bench for mux_op_sequencer: behavioural op-change-only mux, bundle-level
// reference model with an expected-word queue, directed cases plus random bundles.
module tb_mux_op_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0, in_b = '0, in_c = '0, in_d = '0;
  logic [3:0]   in_mask = '0;
  logic [W-1:0] mux_a, mux_b, mux_c, mux_d;
  logic [1:0]   mux_op;
  logic [W-1:0] mux_out = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [1:0]   out_idx;
  logic         out_last;
  logic         busy;
  logic [2:0]   state_dbg;

  mux_op_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .in_mask(in_mask),
    .mux_a(mux_a), .mux_b(mux_b), .mux_c(mux_c), .mux_d(mux_d), .mux_op(mux_op),
    .mux_out(mux_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .busy(busy),
    .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream mux: output refreshes only when op changes.
  always @(mux_op) begin
    case (mux_op)
      2'd0:    mux_out = mux_a;
      2'd1:    mux_out = mux_b;
      2'd2:    mux_out = mux_c;
      default: mux_out = mux_d;
    endcase
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // scoreboard: entries are {last, idx, data}
  logic [W+2:0] exp_q[$];
  logic [W+2:0] head;
  logic         in_flight = 1'b0;
  logic         rst_prev = 1'b0;
  int           nv = 0;
  int           hs_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_in_ready", 32'(in_ready), 32'd0);
      if (rst_prev) begin
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mux_op", 32'(mux_op), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
      end
      exp_q.delete();
      in_flight = 1'b0;
      rst_prev  = 1'b1;
    end else begin
      rst_prev = 1'b0;
      check("in_ready", 32'(in_ready), 32'(!in_flight));
      check("busy", 32'(busy), 32'(in_flight));
      check("out_valid", 32'(out_valid), 32'(in_flight && cyc >= nv));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 32'(out_data), 32'hdead_beef);
        end else begin
          head = exp_q[0];
          check("out_data", 32'(out_data), 32'(head[W-1:0]));
          check("out_idx", 32'(out_idx), 32'(head[W+1:W]));
          check("out_last", 32'(out_last), 32'(head[W+2]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            hs_cnt++;
            if (head[W+2]) in_flight = 1'b0;
            else nv = cyc + 4;
          end
        end
      end
      if (in_valid && in_ready) begin
        logic [3:0]   m;
        logic [W-1:0] words [4];
        int           top;
        m = (in_mask == 4'b0000) ? 4'b1111 : in_mask;
        words[0] = in_a; words[1] = in_b; words[2] = in_c; words[3] = in_d;
        top = 0;
        for (int i = 0; i < 4; i++) if (m[i]) top = i;
        for (int i = 0; i < 4; i++)
          if (m[i]) exp_q.push_back({(i == top), 2'(i), words[i]});
        in_flight = 1'b1;
        nv = cyc + 4;
      end
    end
  end

  // driver tasks
  logic rdy_random = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
    if (rdy_random) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [W-1:0] a, b, c, d, input logic [3:0] m);
    bit done = 0;
    in_a = a; in_b = b; in_c = c; in_d = d; in_mask = m;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      if (in_ready) done = 1;
      step();
    end
    in_valid = 1'b0;
    if (!done) check("accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (!in_flight) done = 1;
      else step();
    end
    if (!done) check("idle_timeout", 32'd1, 32'd0);
    step();
  endtask

  task automatic wait_valid();
    bit done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      if (out_valid) done = 1;
      else step();
    end
    if (!done) check("valid_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int base;
    bit done;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // 1: full mask
    out_ready = 1'b1;
    send(16'h0007, 16'hFFFD, 16'h0038, 16'hF16D, 4'hF);
    wait_idle();

    // 2: single top word after a bundle that ended on idx 3
    send(16'h0007, 16'hFFFD, 16'h0038, 16'h1234, 4'b1000);
    wait_idle();

    // 3: zero mask means all words
    send(16'h0008, 16'h0004, 16'h0045, 16'hF0FD, 4'b0000);
    wait_idle();

    // 4: backpressure on second word
    base = hs_cnt;
    send(W'($urandom), W'($urandom), W'($urandom), W'($urandom), 4'b0101);
    done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      if (hs_cnt != base) done = 1;
      else step();
    end
    if (!done) check("first_hs_timeout", 32'd1, 32'd0);
    out_ready = 1'b0;
    wait_valid();
    repeat (5) step();
    out_ready = 1'b1;
    wait_idle();

    // 5: new bundles offered while busy are ignored
    send(16'h1111, 16'h2222, 16'h3333, 16'h4444, 4'hF);
    for (int i = 0; i < 6; i++) begin
      in_valid = ~in_valid;
      in_a = W'($urandom); in_b = W'($urandom); in_c = W'($urandom); in_d = W'($urandom);
      in_mask = 4'($urandom);
      step();
    end
    in_valid = 1'b0;
    wait_idle();

    // 6: reset during EMIT, then a clean bundle
    out_ready = 1'b0;
    send(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 4'hF);
    wait_valid();
    step();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();
    out_ready = 1'b1;
    send(16'h0102, 16'h0304, 16'h0506, 16'h0708, 4'b0110);
    wait_idle();

    // random bundles with random consumer stalls
    rdy_random = 1'b1;
    for (int n = 0; n < 40; n++) begin
      send(W'($urandom), W'($urandom), W'($urandom), W'($urandom), 4'($urandom_range(0, 15)));
      wait_idle();
    end
    rdy_random = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
